// File: rtl/dom_conv_sched.sv
// Round-robin burst scheduler: grants one output-block FIFO at a time and
// streams BURST_LEN beats from it toward the domain converter, tagging each beat.
module dom_conv_sched #(
  parameter int FIFO_NUM_O_BLK = 4,
  parameter int I_DATA_WIDTH   = 32,
  parameter int I_FDSSI_WIDTH  = 2,
  parameter int I_SSI_WIDTH    = 8,
  parameter int I_SAM_OFFSET   = 4,
  parameter int BURST_LEN      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [FIFO_NUM_O_BLK-1:0]              blk_avail,
  input  logic [FIFO_NUM_O_BLK-1:0]              blk_nempty,
  input  logic [FIFO_NUM_O_BLK*I_DATA_WIDTH-1:0] blk_data,
  output logic [FIFO_NUM_O_BLK-1:0]              blk_pop,
  output logic                                   valid_o,
  input  logic                                   dn_ready,
  output logic [I_DATA_WIDTH-1:0]                data_o,
  output logic [I_FDSSI_WIDTH-1:0]               FDSSI_o,
  output logic [I_SSI_WIDTH-1:0]                 SSI_o,
  output logic [I_SAM_OFFSET-1:0]                s_o,
  output logic                                   wt_o,
  output logic                                   underrun_o
);

  localparam int NB = FIFO_NUM_O_BLK;
  localparam int DW = I_DATA_WIDTH;
  localparam int FW = I_FDSSI_WIDTH;
  localparam int SW = I_SSI_WIDTH;
  localparam int OW = I_SAM_OFFSET;
  localparam logic [OW-1:0] S_LAST = OW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   grant_q, grant_d;
  logic [FW-1:0]   last_grant_q, last_grant_d;
  logic [OW-1:0]   s_q, s_d;
  logic            underrun_q, underrun_d;
  logic [SW-1:0]   ssi_q [NB];
  logic [SW-1:0]   ssi_d [NB];

  logic [FW-1:0]   winner;
  logic            any_avail;
  logic            sel_nempty;
  logic [DW-1:0]   sel_data;
  logic [SW-1:0]   sel_ssi;
  logic            accept;

  // Round-robin search: distance k=1 is the block right after the last grant.
  always_comb begin
    winner    = '0;
    any_avail = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      for (int i = 0; i < NB; i++) begin
        if (!any_avail && blk_avail[i] && (i == (int'(last_grant_q) + k) % NB)) begin
          any_avail = 1'b1;
          winner    = FW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_nempty = 1'b0;
    sel_data   = '0;
    sel_ssi    = '0;
    for (int i = 0; i < NB; i++) begin
      if (grant_q == FW'(i)) begin
        sel_nempty = blk_nempty[i];
        sel_data   = blk_data[i*DW +: DW];
        sel_ssi    = ssi_q[i];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_d          = s_q;
    underrun_d   = underrun_q;
    ssi_d        = ssi_q;
    accept       = 1'b0;
    blk_pop      = '0;
    valid_o      = 1'b0;
    data_o       = '0;
    FDSSI_o      = '0;
    SSI_o        = '0;
    s_o          = '0;
    wt_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && any_avail) begin
          state_d      = BURST;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      BURST: begin
        valid_o = sel_nempty;
        data_o  = sel_data;
        FDSSI_o = grant_q;
        SSI_o   = sel_ssi;
        s_o     = s_q;
        wt_o    = (s_q == S_LAST);
        accept  = sel_nempty & dn_ready;
        if (!sel_nempty) underrun_d = 1'b1;
        for (int i = 0; i < NB; i++) begin
          blk_pop[i] = accept && (grant_q == FW'(i));
        end
        if (accept) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            for (int i = 0; i < NB; i++) begin
              if (grant_q == FW'(i)) ssi_d[i] = ssi_q[i] + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must not consume a word from the FIFO being aborted.
    if (rst) begin
      valid_o = 1'b0;
      blk_pop = '0;
    end
  end

  assign underrun_o = underrun_q;

  // NOTE: sequential state uses <= so every flop samples its pre-edge input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= FW'(NB - 1);
      s_q          <= '0;
      underrun_q   <= 1'b0;
      // NOTE: the SSI counters are ordinary flops, so each entry takes the reset.
      for (int i = 0; i < NB; i++) ssi_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_q          <= s_d;
      underrun_q   <= underrun_d;
      for (int i = 0; i < NB; i++) ssi_q[i] <= ssi_d[i];
    end
  end

endmodule

// File: tb/tb_dom_conv_sched.sv
// Bench for dom_conv_sched: per-block FIFO queues feed the DUT and a
// transaction-level model predicts every output each cycle.
module tb_dom_conv_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FW = 2;
  localparam int SW = 8;
  localparam int OW = 4;
  localparam int BL = 8;

  logic            clk = 1'b0;
  logic            rst, enable, dn_ready;
  logic [N-1:0]    blk_avail, blk_nempty, blk_pop;
  logic [N*DW-1:0] blk_data;
  logic            valid_o, wt_o, underrun_o;
  logic [DW-1:0]   data_o;
  logic [FW-1:0]   FDSSI_o;
  logic [SW-1:0]   SSI_o;
  logic [OW-1:0]   s_o;

  dom_conv_sched #(
    .FIFO_NUM_O_BLK(N), .I_DATA_WIDTH(DW), .I_FDSSI_WIDTH(FW),
    .I_SSI_WIDTH(SW), .I_SAM_OFFSET(OW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .blk_avail(blk_avail),
    .blk_nempty(blk_nempty), .blk_data(blk_data), .blk_pop(blk_pop),
    .valid_o(valid_o), .dn_ready(dn_ready), .data_o(data_o),
    .FDSSI_o(FDSSI_o), .SSI_o(SSI_o), .s_o(s_o), .wt_o(wt_o),
    .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int n_checks, n_errors;

  // External FIFOs and a per-block mask that hides a non-empty head.
  logic [DW-1:0] fifo_q [N][$];

  // Model: whether a burst is running, on which block, beats done so far.
  bit m_busy;
  int m_blk, m_beats, m_last, m_under;
  int m_ssi [N];

  // Observations taken from the DUT for the literal expectations.
  int obs_pops, obs_valid;
  int end_blk [$];
  int end_ssi [$];
  int acc_s [$];

  int exp_blk2 [5] = '{0, 1, 2, 3, 0};
  int exp_ssi2 [5] = '{0, 0, 0, 0, 1};
  bit rdy_pat3 [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_end(input string name, input int idx, input int blk, input int ssi);
    if (end_blk.size() > idx) begin
      check({name, "_blk"}, 64'(end_blk[idx]), 64'(blk));
      check({name, "_ssi"}, 64'(end_ssi[idx]), 64'(ssi));
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: burst %0d never finished, got %0d bursts", name, idx, end_blk.size());
    end
  endtask

  task automatic push_words(input int b, input int n);
    for (int k = 0; k < n; k++) fifo_q[b].push_back($urandom());
  endtask

  task automatic clear_obs();
    obs_pops  = 0;
    obs_valid = 0;
    end_blk.delete();
    end_ssi.delete();
    acc_s.delete();
  endtask

  // One clock: apply inputs at negedge, compare before the posedge, advance model.
  task automatic cycle(input logic r, input logic en, input logic rdy, input logic [N-1:0] hd);
    logic            head_ok, exp_v, exp_acc;
    logic [DW-1:0]   exp_d;
    logic [N-1:0]    exp_pop;
    int              best, bestd, d;
    @(negedge clk);
    rst      = r;
    enable   = en;
    dn_ready = rdy;
    for (int i = 0; i < N; i++) begin
      blk_avail[i]         = fifo_q[i].size() >= BL;
      blk_nempty[i]        = (fifo_q[i].size() > 0) && !hd[i];
      blk_data[i*DW +: DW] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
    end
    #2;
    head_ok = m_busy && (fifo_q[m_blk].size() > 0) && !hd[m_blk];
    exp_v   = head_ok;
    exp_acc = exp_v && rdy;
    exp_pop = '0;
    if (exp_acc) exp_pop[m_blk] = 1'b1;
    exp_d = '0;
    if (m_busy && fifo_q[m_blk].size() > 0) exp_d = fifo_q[m_blk][0];

    if (r) begin
      check("valid_in_reset", 64'(valid_o), 64'(0));
      check("pop_in_reset", 64'(blk_pop), 64'(0));
    end else begin
      check("valid_o", 64'(valid_o), 64'(exp_v));
      check("blk_pop", 64'(blk_pop), 64'(exp_pop));
      check("data_o", 64'(data_o), 64'(exp_d));
      check("FDSSI_o", 64'(FDSSI_o), 64'(m_busy ? m_blk : 0));
      check("SSI_o", 64'(SSI_o), 64'(m_busy ? m_ssi[m_blk] : 0));
      check("s_o", 64'(s_o), 64'(m_busy ? m_beats : 0));
      check("wt_o", 64'(wt_o), 64'(m_busy && m_beats == BL - 1));
      check("underrun_o", 64'(underrun_o), 64'(m_under));
      obs_valid += int'(valid_o);
      if (blk_pop != '0) obs_pops++;
      if (valid_o && dn_ready) begin
        acc_s.push_back(int'(s_o));
        if (wt_o) begin
          end_blk.push_back(int'(FDSSI_o));
          end_ssi.push_back(int'(SSI_o));
        end
      end
    end

    if (r) begin
      m_busy  = 0;
      m_beats = 0;
      m_under = 0;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_ssi[i] = 0;
    end else if (m_busy) begin
      if (!head_ok) m_under = 1;
      if (exp_acc) begin
        void'(fifo_q[m_blk].pop_front());
        m_beats++;
        if (m_beats == BL) begin
          m_busy         = 0;
          m_beats        = 0;
          m_ssi[m_blk]   = (m_ssi[m_blk] + 1) % (1 << SW);
        end
      end
    end else if (en) begin
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_last - 1 + N) % N;
        if (blk_avail[i] && d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
      if (best >= 0) begin
        m_busy = 1;
        m_blk  = best;
        m_last = best;
      end
    end
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int cyc, hid;
    logic [N-1:0] hd;
    logic r, en, rdy;
    rst = 1'b1; enable = 1'b0; dn_ready = 1'b0;
    blk_avail = '0; blk_nempty = '0; blk_data = '0;
    n_checks = 0; n_errors = 0;
    m_busy = 0; m_blk = 0; m_beats = 0; m_under = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) m_ssi[i] = 0;
    clear_obs();

    // Single block 0 burst.
    reset_dut();
    check("t1_reset_valid", 64'(valid_o), 64'(0));
    check("t1_reset_underrun", 64'(underrun_o), 64'(0));
    push_words(0, 8);
    clear_obs();
    repeat (12) cycle(1'b0, 1'b1, 1'b1, '0);
    check("t1_pops", 64'(obs_pops), 64'(8));
    check("t1_bursts", 64'(end_blk.size()), 64'(1));
    check_end("t1_end", 0, 0, 0);
    check("t1_beats", 64'(acc_s.size()), 64'(8));
    for (int k = 0; k < acc_s.size() && k < 8; k++) check("t1_s_seq", 64'(acc_s[k]), 64'(k));

    // All blocks available: round-robin 0,1,2,3,0 with one bubble between bursts.
    reset_dut();
    push_words(0, 16);
    push_words(1, 8);
    push_words(2, 8);
    push_words(3, 8);
    clear_obs();
    repeat (45) cycle(1'b0, 1'b1, 1'b1, '0);
    check("t2_bursts", 64'(end_blk.size()), 64'(5));
    for (int k = 0; k < 5; k++) check_end("t2_end", k, exp_blk2[k], exp_ssi2[k]);
    check("t2_valid_beats", 64'(obs_valid), 64'(40));

    // Downstream back-pressure mid-burst.
    reset_dut();
    push_words(1, 8);
    clear_obs();
    cycle(1'b0, 1'b1, 1'b1, '0);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, rdy_pat3[k], '0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, '0);
    check("t3_pops", 64'(obs_pops), 64'(8));
    check_end("t3_end", 0, 1, 0);
    for (int k = 0; k < acc_s.size() && k < 8; k++) check("t3_s_seq", 64'(acc_s[k]), 64'(k));

    // Granted FIFO runs dry at s_o=3 for two cycles.
    reset_dut();
    push_words(2, 8);
    clear_obs();
    hid = 0;
    cyc = 0;
    while (end_blk.size() < 1 && cyc < 40) begin
      hd = '0;
      if (m_busy && m_beats == 3 && hid < 2) hd[2] = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, hd);
      if (hd[2]) begin
        hid++;
        check("t4_stall_valid", 64'(valid_o), 64'(0));
        check("t4_stall_s", 64'(s_o), 64'(3));
      end
      cyc++;
    end
    repeat (3) cycle(1'b0, 1'b1, 1'b1, '0);
    check("t4_underrun_sticky", 64'(underrun_o), 64'(1));
    check("t4_pops", 64'(obs_pops), 64'(8));
    check_end("t4_end", 0, 2, 0);

    // Reset while block 1 is at s_o=5; next grant must favour block 0 again.
    reset_dut();
    push_words(1, 8);
    push_words(3, 8);
    cyc = 0;
    while (!(m_busy && m_beats == 5) && cyc < 30) begin
      cycle(1'b0, 1'b1, 1'b1, '0);
      cyc++;
    end
    cycle(1'b1, 1'b1, 1'b1, '0);
    check("t5_s_at_rst", 64'(s_o), 64'(5));
    check("t5_no_pop_at_rst", 64'(blk_pop), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("t5_after_valid", 64'(valid_o), 64'(0));
    check("t5_after_s", 64'(s_o), 64'(0));
    check("t5_after_wt", 64'(wt_o), 64'(0));
    push_words(0, 8);
    clear_obs();
    repeat (25) cycle(1'b0, 1'b1, 1'b1, '0);
    check_end("t5_first", 0, 0, 0);
    check_end("t5_second", 1, 3, 0);

    // SSI wrap on block 2 after 256 bursts.
    reset_dut();
    push_words(2, 257 * BL);
    clear_obs();
    cyc = 0;
    while (end_blk.size() < 257 && cyc < 3000) begin
      cycle(1'b0, 1'b1, 1'b1, '0);
      cyc++;
    end
    check("t6_bursts", 64'(end_blk.size()), 64'(257));
    check_end("t6_b254", 254, 2, 254);
    check_end("t6_b255", 255, 2, 255);
    check_end("t6_wrap", 256, 2, 0);

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        if (fifo_q[b].size() < 24) push_words(b, $urandom_range(1, 8));
      end
      r   = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      hd  = '0;
      if ($urandom_range(0, 15) == 0) hd = N'($urandom_range(0, (1 << N) - 1));
      cycle(r, en, rdy, hd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
